// File: rtl/fifo_arb_pkg.sv
// Types, constants and the round-robin helper shared by the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int STALL_CNT_W = 16;
    localparam int MAX_REQ     = 16;
    localparam int MAX_ID_W    = 4;

    // Winner is the first valid index after last_id, wrapping modulo num_req.
    // Scanning from the far end lets the nearest valid index overwrite the result.
    function automatic logic [MAX_ID_W-1:0] rr_next(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        last_id,
        input int unsigned        num_req
    );
        logic [MAX_ID_W-1:0] idx;
        rr_next = {MAX_ID_W{1'b0}};
        for (int unsigned k = MAX_REQ; k >= 1; k--) begin
            if (k <= num_req) begin
                idx = MAX_ID_W'((last_id + k) % num_req);
                if (valid[idx]) begin
                    rr_next = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake and FIFO write-port bundle for the write-port arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wdata;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wdata
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wdata
    );
endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_id.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] last_id,
    output logic                any_valid,
    output logic [ID_WIDTH-1:0] win_id
);
    logic [MAX_REQ-1:0] valid_ext_s;

    // Zero-extend the request vector so the shared helper sees a fixed width.
    always_comb begin
        valid_ext_s              = {MAX_REQ{1'b0}};
        valid_ext_s[NUM_REQ-1:0] = valid;
        any_valid                = |valid;
        win_id                   = ID_WIDTH'(rr_next(valid_ext_s, 32'(last_id), 32'(NUM_REQ)));
    end
endmodule

// File: rtl/fifo_wr_arbiter_chk.sv
// Safety properties of the arbiter write port.
module fifo_wr_arbiter_chk #(
    parameter int NUM_REQ = 4
) (
    input logic               wrclk,
    input logic               rdrst_n,
    input logic               fifo_full,
    input logic               fifo_wr_en,
    input logic [NUM_REQ-1:0] req_ready
);
    a_no_write_when_full: assert property (@(posedge wrclk) disable iff (!rdrst_n)
        !(fifo_wr_en && fifo_full));

    a_ready_onehot0: assert property (@(posedge wrclk) disable iff (!rdrst_n)
        $onehot0(req_ready));
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                   wrclk,
    input  logic                   rdrst_n,
    fifo_wr_arbiter_if.slave       bus,
    output logic                   grant_active,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int BEAT_W = $clog2(MAX_BURST);

    arb_state_e             state_r, state_nxt_s;
    logic [ID_WIDTH-1:0]    grant_id_r, grant_id_nxt_s;
    logic [ID_WIDTH-1:0]    last_id_r, last_id_nxt_s;
    logic [BEAT_W-1:0]      beat_cnt_r, beat_cnt_nxt_s;
    logic                   grant_active_r, grant_active_nxt_s;
    logic [STALL_CNT_W-1:0] stall_cnt_r, stall_cnt_nxt_s;
    logic                   any_valid_s, accept_s, burst_end_s, stall_s;
    logic [ID_WIDTH-1:0]    win_id_s;
    logic [NUM_REQ-1:0]     req_ready_s;
    logic [DATA_WIDTH-1:0]  wdata_s;
    logic [DATA_WIDTH-1:0]  req_beat_s [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_beat
        assign req_beat_s[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    fifo_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .valid     (bus.req_valid),
        .last_id   (last_id_r),
        .any_valid (any_valid_s),
        .win_id    (win_id_s)
    );

    // Next-state decode plus the same-cycle handshake and FIFO write-port mux.
    always_comb begin
        state_nxt_s        = state_r;
        grant_id_nxt_s     = grant_id_r;
        last_id_nxt_s      = last_id_r;
        beat_cnt_nxt_s     = beat_cnt_r;
        grant_active_nxt_s = grant_active_r;
        accept_s           = 1'b0;
        burst_end_s        = 1'b0;
        stall_s            = 1'b0;
        req_ready_s        = {NUM_REQ{1'b0}};
        wdata_s            = {DATA_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    state_nxt_s        = BURST;
                    grant_id_nxt_s     = win_id_s;
                    beat_cnt_nxt_s     = {BEAT_W{1'b0}};
                    grant_active_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                // fifo_full gates the write in the same cycle; nothing is buffered here.
                req_ready_s[grant_id_r] = ~bus.fifo_full;
                accept_s    = bus.req_valid[grant_id_r] & ~bus.fifo_full;
                stall_s     = bus.req_valid[grant_id_r] & bus.fifo_full;
                wdata_s     = req_beat_s[grant_id_r];
                burst_end_s = accept_s & (bus.req_last[grant_id_r] |
                                          (beat_cnt_r == BEAT_W'(MAX_BURST - 1)));
                if (burst_end_s) begin
                    state_nxt_s        = IDLE;
                    last_id_nxt_s      = grant_id_r;
                    grant_active_nxt_s = 1'b0;
                end else if (accept_s) begin
                    beat_cnt_nxt_s = beat_cnt_r + BEAT_W'(1'b1);
                end else begin
                    state_nxt_s = BURST;
                end
            end
            default: begin
                state_nxt_s        = IDLE;
                grant_active_nxt_s = 1'b0;
            end
        endcase
    end

    // Stall counter saturates instead of wrapping.
    always_comb begin
        if (stall_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_nxt_s = stall_cnt_r + STALL_CNT_W'(1'b1);
        end else begin
            stall_cnt_nxt_s = stall_cnt_r;
        end
    end

    // State and counter registers; reset abandons any burst in flight.
    always_ff @(posedge wrclk or negedge rdrst_n) begin
        if (!rdrst_n) begin
            state_r        <= IDLE;
            grant_id_r     <= {ID_WIDTH{1'b0}};
            last_id_r      <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt_r     <= {BEAT_W{1'b0}};
            grant_active_r <= 1'b0;
            stall_cnt_r    <= {STALL_CNT_W{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            grant_id_r     <= grant_id_nxt_s;
            last_id_r      <= last_id_nxt_s;
            beat_cnt_r     <= beat_cnt_nxt_s;
            grant_active_r <= grant_active_nxt_s;
            stall_cnt_r    <= stall_cnt_nxt_s;
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.fifo_wr_en = accept_s;
    assign bus.fifo_wdata = wdata_s;
    assign grant_active   = grant_active_r;
    assign grant_id       = grant_id_r;
    assign stall_cnt      = stall_cnt_r;

    fifo_wr_arbiter_chk #(
        .NUM_REQ (NUM_REQ)
    ) u_chk (
        .wrclk      (wrclk),
        .rdrst_n    (rdrst_n),
        .fifo_full  (bus.fifo_full),
        .fifo_wr_en (accept_s),
        .req_ready  (req_ready_s)
    );
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences, random traffic vs. a reference model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;
    localparam int IDW  = 2;

    logic                   wrclk = 1'b0;
    logic                   rdrst_n;
    logic                   grant_active;
    logic [IDW-1:0]         grant_id;
    logic [STALL_CNT_W-1:0] stall_cnt;

    fifo_wr_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NREQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .ID_WIDTH   (IDW)
    ) dut (
        .wrclk        (wrclk),
        .rdrst_n      (rdrst_n),
        .bus          (bus),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .stall_cnt    (stall_cnt)
    );

    always #5 wrclk = ~wrclk;

    typedef struct {
        logic [NREQ-1:0]    valid;
        logic [NREQ-1:0]    last;
        logic [NREQ*DW-1:0] data;
        logic               exp_wr;
        logic [DW-1:0]      exp_wdata;
        logic [NREQ-1:0]    exp_ready;
        logic               exp_active;
        logic [IDW-1:0]     exp_gid;
    } vec_t;

    vec_t       tbl [$];
    logic [8:0] pq [NREQ][$];
    logic [7:0] wlog [$];
    logic [7:0] exp_q [$];
    logic       full_q;
    bit         gaps;
    int         vectors = 0;
    int         miscompares = 0;

    // Reference model: who owns the port, beats taken this grant, previous winner, stalls.
    bit m_busy;
    int m_owner, m_count, m_prev, m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                                    input logic [NREQ*DW-1:0] d, input logic ew,
                                    input logic [DW-1:0] ewd, input logic [NREQ-1:0] er,
                                    input logic ea, input logic [IDW-1:0] eg);
        vec_t r;
        r.valid = v; r.last = l; r.data = d;
        r.exp_wr = ew; r.exp_wdata = ewd; r.exp_ready = er; r.exp_active = ea; r.exp_gid = eg;
        tbl.push_back(r);
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_count = 0; m_prev = NREQ - 1; m_stall = 0;
    endtask

    task automatic model_step();
        bit found;
        if (!rdrst_n) begin
            model_reset();
        end else if (m_busy) begin
            if (bus.req_valid[m_owner] && bus.fifo_full && m_stall < 65535) m_stall++;
            if (bus.req_valid[m_owner] && !bus.fifo_full) begin
                m_count++;
                if (bus.req_last[m_owner] || m_count == MB) begin
                    m_busy = 1'b0;
                    m_prev = m_owner;
                end
            end
        end else if (bus.req_valid != '0) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && bus.req_valid[(m_prev + k) % NREQ]) begin
                    m_owner = (m_prev + k) % NREQ;
                    found = 1'b1;
                end
            end
            m_busy = 1'b1;
            m_count = 0;
        end
    endtask

    // Present the front beat of each producer queue (optionally with random gaps).
    task automatic drive();
        logic [NREQ-1:0]    v, l;
        logic [NREQ*DW-1:0] d;
        logic [8:0]         b;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pq[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                b = pq[i][0];
                v[i] = 1'b1;
                l[i] = b[8];
                d[i*DW +: DW] = b[7:0];
            end
        end
        bus.req_valid = v; bus.req_last = l; bus.req_data = d; bus.fifo_full = full_q;
    endtask

    task automatic eval();
        logic [NREQ-1:0] e_ready;
        logic            e_wr;
        logic [DW-1:0]   e_wdata;
        #1;
        if (!rdrst_n) model_reset();
        e_ready = '0; e_wr = 1'b0; e_wdata = '0;
        if (m_busy) begin
            e_ready[m_owner] = !bus.fifo_full;
            e_wr             = bus.req_valid[m_owner] && !bus.fifo_full;
            e_wdata          = bus.req_data[m_owner*DW +: DW];
        end
        chk("wr_en",     32'(bus.fifo_wr_en), 32'(e_wr));
        chk("wdata",     32'(bus.fifo_wdata), 32'(e_wdata));
        chk("req_ready", 32'(bus.req_ready),  32'(e_ready));
        chk("active",    32'(grant_active),   32'(m_busy));
        chk("grant_id",  32'(grant_id),       32'(m_owner));
        chk("stall_cnt", 32'(stall_cnt),      32'(m_stall));
    endtask

    task automatic adv();
        logic [NREQ-1:0] pop;
        pop = bus.req_ready & bus.req_valid;
        if (bus.fifo_wr_en) wlog.push_back(bus.fifo_wdata);
        model_step();
        @(posedge wrclk);
        for (int i = 0; i < NREQ; i++) begin
            if (pop[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        @(negedge wrclk);
    endtask

    task automatic tick();
        drive(); eval(); adv();
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, 32'(wlog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) chk(name, 32'(wlog[i]), 32'(exp_q[i]));
        wlog.delete();
    endtask

    task automatic load(input int id, input logic [7:0] first, input int len);
        for (int j = 0; j < len; j++) pq[id].push_back({1'(j == len - 1), 8'(first + 8'(j))});
    endtask

    initial begin
        rdrst_n = 1'b0; full_q = 1'b0; gaps = 1'b0;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
        model_reset();

        // Round-robin with 1-beat packets from all four, then req1 sends 11,22,33.
        add_vec(4'hF, 4'hF, 32'hC3C2C1C0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        add_vec(4'hF, 4'hF, 32'hC3C2C1C0, 1'b1, 8'hC0, 4'b0001, 1'b1, 2'd0);
        add_vec(4'hF, 4'hF, 32'hC3C2C1C0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        add_vec(4'hF, 4'hF, 32'hC3C2C1C0, 1'b1, 8'hC1, 4'b0010, 1'b1, 2'd1);
        add_vec(4'hF, 4'hF, 32'hC3C2C1C0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1);
        add_vec(4'hF, 4'hF, 32'hC3C2C1C0, 1'b1, 8'hC2, 4'b0100, 1'b1, 2'd2);
        add_vec(4'hF, 4'hF, 32'hC3C2C1C0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2);
        add_vec(4'hF, 4'hF, 32'hC3C2C1C0, 1'b1, 8'hC3, 4'b1000, 1'b1, 2'd3);
        add_vec(4'hF, 4'hF, 32'hC3C2C1C0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3);
        add_vec(4'hF, 4'hF, 32'hC3C2C1C0, 1'b1, 8'hC0, 4'b0001, 1'b1, 2'd0);
        add_vec(4'h0, 4'h0, 32'h00000000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        add_vec(4'h2, 4'h0, 32'h00001100, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        add_vec(4'h2, 4'h0, 32'h00001100, 1'b1, 8'h11, 4'b0010, 1'b1, 2'd1);
        add_vec(4'h2, 4'h0, 32'h00002200, 1'b1, 8'h22, 4'b0010, 1'b1, 2'd1);
        add_vec(4'h2, 4'h2, 32'h00003300, 1'b1, 8'h33, 4'b0010, 1'b1, 2'd1);
        add_vec(4'h0, 4'h0, 32'h00000000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1);

        @(negedge wrclk);

        // Reset held three cycles, then idle.
        for (int c = 0; c < 3; c++) tick();
        rdrst_n = 1'b1;
        for (int c = 0; c < 2; c++) tick();
        chk("idle_active", 32'(grant_active),   32'd0);
        chk("idle_wr_en",  32'(bus.fifo_wr_en), 32'd0);
        chk("idle_stall",  32'(stall_cnt),      32'd0);
        chk("idle_gid",    32'(grant_id),       32'd0);

        foreach (tbl[r]) begin
            bus.req_valid = tbl[r].valid; bus.req_last = tbl[r].last;
            bus.req_data  = tbl[r].data;  bus.fifo_full = 1'b0;
            eval();
            chk("tbl_wr_en",  32'(bus.fifo_wr_en), 32'(tbl[r].exp_wr));
            chk("tbl_wdata",  32'(bus.fifo_wdata), 32'(tbl[r].exp_wdata));
            chk("tbl_ready",  32'(bus.req_ready),  32'(tbl[r].exp_ready));
            chk("tbl_active", 32'(grant_active),   32'(tbl[r].exp_active));
            chk("tbl_gid",    32'(grant_id),       32'(tbl[r].exp_gid));
            adv();
        end
        wlog.delete();

        // Burst cut: req2 has six beats, req3 one beat waiting.
        load(2, 8'hA0, 6);
        load(3, 8'hB0, 1);
        for (int c = 0; c < 12; c++) tick();
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hA4, 8'hA5};
        check_log("cut_order");

        // Back-pressure: fifo_full for five cycles after the first beat of req0.
        load(0, 8'h50, 4);
        for (int c = 0; c < 2; c++) tick();
        full_q = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(); eval();
            chk("bp_wr_en",  32'(bus.fifo_wr_en),   32'd0);
            chk("bp_ready0", 32'(bus.req_ready[0]), 32'd0);
            adv();
        end
        full_q = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("bp_stall_cnt", 32'(stall_cnt), 32'd5);
        exp_q = '{8'h50, 8'h51, 8'h52, 8'h53};
        check_log("bp_order");

        // Reset after the second beat of a four-beat burst.
        load(0, 8'h60, 4);
        for (int c = 0; c < 3; c++) tick();
        rdrst_n = 1'b0;
        drive(); eval();
        chk("rst_wr_en",  32'(bus.fifo_wr_en), 32'd0);
        chk("rst_ready",  32'(bus.req_ready),  32'd0);
        chk("rst_wdata",  32'(bus.fifo_wdata), 32'd0);
        chk("rst_active", 32'(grant_active),   32'd0);
        chk("rst_stall",  32'(stall_cnt),      32'd0);
        adv();
        load(1, 8'h70, 1);
        tick();
        rdrst_n = 1'b1;
        tick();
        drive(); eval();
        chk("rst_regrant_gid",    32'(grant_id),     32'd0);
        chk("rst_regrant_active", 32'(grant_active), 32'd1);
        adv();
        for (int c = 0; c < 8; c++) tick();
        exp_q = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h70};
        check_log("rst_order");

        // Random traffic: gaps, back-pressure and rare resets.
        gaps = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            full_q  = ($urandom_range(0, 4) == 0);
            rdrst_n = ($urandom_range(0, 599) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (pq[i].size() == 0 && $urandom_range(0, 2) == 0)
                    load(i, 8'($urandom_range(0, 255)), int'($urandom_range(1, 7)));
            end
            tick();
        end
        rdrst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's asynchronous FIFO among NUM_REQ producers in the write clock domain.
- Arbitrates round-robin and grants one requester at a time for a burst.
- A burst ends on the requester's last beat or after MAX_BURST beats.
- Drives the FIFO wr_en and data_in from the granted requester and back-pressures all producers on fifo_full.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, FIFO data width.
- MAX_BURST, 4, maximum beats per grant (power of 2, ≥2).
- ID_WIDTH, $clog2(NUM_REQ), derived; width of grant_id.

Ports:
- wrclk  in  1  write-domain clock; all logic is rising-edge.
- rdrst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester final beat of packet.
- req_data  in  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester beat accepted this cycle.
- fifo_full  in  1  registered full flag from the FIFO write side.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wdata  out  DATA_WIDTH  FIFO write data.
- grant_active  out  1  a burst is in progress.
- grant_id  out  ID_WIDTH  index of the granted requester.
- stall_cnt  out  16  saturating count of cycles where a granted valid beat was blocked by fifo_full.

Behaviour:
- Reset (async, rdrst_n=0):
  - state=IDLE; grant_active=0; grant_id=0; beat_cnt=0; stall_cnt=0.
  - Round-robin pointer last_id=NUM_REQ-1, so requester 0 wins first.
  - Combinational outputs evaluate to req_ready=0, fifo_wr_en=0, fifo_wdata=0.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid: pick the first valid index scanning last_id+1, last_id+2, … modulo NUM_REQ.
  - Register it into grant_id; grant_active<=1; beat_cnt<=0; go BURST.
  - Arbitration latency is 1 cycle from valid to first possible accept.
  - If no req_valid, stay IDLE.
- BURST, accept rule (combinational):
  - accept = req_valid[grant_id] & !fifo_full.
  - req_ready[grant_id] = !fifo_full; all other req_ready bits = 0.
  - fifo_wr_en = accept; fifo_wdata = req_data slice of grant_id.
  - Outside BURST: fifo_wr_en=0, fifo_wdata=0, req_ready=0.
- BURST, on accept:
  - If req_last[grant_id], or beat_cnt==MAX_BURST-1: burst ends. last_id<=grant_id; grant_active<=0; go IDLE.
  - Otherwise beat_cnt<=beat_cnt+1.
- Grant is held while the granted requester deasserts valid mid-burst; other requesters wait. Packet atomicity takes priority over fairness.
- Every burst end is followed by exactly one IDLE cycle, so no back-to-back grants without a bubble.
- Stall counting: stall_cnt increments when state==BURST & req_valid[grant_id] & fifo_full. It saturates at 16'hFFFF and never wraps.
- fifo_full is never registered locally. Gating is same-cycle, so no beat is ever presented to the FIFO while full and no data is lost.
- A MAX_BURST cut with req_last=0 leaves the packet unfinished. The requester re-competes in a later round-robin cycle, with normal priority rotation.
- Reset asserted mid-burst: immediate return to IDLE; the partial burst is abandoned; counters cleared.
- fifo_wr_en must never be 1 when fifo_full=1 (assertion).
- At most one req_ready bit is ever high (assertion).

Decomposition:
- Package fifo_arb_pkg:
  - State enum (IDLE, BURST).
  - Constant STALL_CNT_W=16.
  - Function rr_next(valid, last_id) returning the winning index.
- One sub-module, fifo_rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: valid vector, last_id. Outputs: any_valid, win_id.
  - The FSM, beat counter, data mux and stall counter stay in fifo_wr_arbiter.

Test Plan (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4):
- Reset then idle: rdrst_n low 3 cycles, no valids → grant_active=0, fifo_wr_en=0, stall_cnt=0, grant_id=0.
- Single requester: req1 sends 0x11,0x22,0x33 (last on 0x33), fifo_full=0 → first accept 1 cycle after valid; fifo_wdata 0x11,0x22,0x33 on consecutive cycles; then one IDLE cycle.
- Round-robin fairness: all four hold valid with 1-beat packets (last=1) → grant order 0,1,2,3,0; each write separated by one IDLE cycle.
- Burst cut: req2 sends 6 beats 0xA0..0xA5, last on 0xA5, with req3 also valid → 0xA0..0xA3 written, then req3 granted, then req2 resumes with 0xA4,0xA5.
- Full back-pressure: force fifo_full=1 for 5 cycles mid-burst of req0 → fifo_wr_en=0 and req_ready[0]=0 throughout; stall_cnt=5; data order unchanged after full drops.
- Reset mid-burst: assert rdrst_n low after beat 2 of a 4-beat burst → outputs zero within the same cycle; after release, requester 0 is granted first if valid.
